// File: rtl/pipelined_alu_core.sv
// Three-stage (ID, EX, WB) accumulator-style ALU core with register file and valid/ready handshakes.
// Optional macro PIPE_FWD_EN: forward the EX result into ID instead of interlocking on RAW hazards.
module pipelined_alu_core #(
  parameter int DATA_W = 8,
  parameter int IMM_W = 8,
  parameter int REG_AW = 2,
  localparam int INSTR_W = 4 + 2*REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [DATA_W-1:0]  result_out,
  output logic [REG_AW-1:0]  result_rd,
  output logic               result_carry,
  output logic               illegal_op
);

  localparam int NREGS = 2**REG_AW;

  logic [DATA_W-1:0]  rf [NREGS];

  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [3:0]         id_op;
  logic [REG_AW-1:0]  id_rd;
  logic [REG_AW-1:0]  id_rs;
  logic [IMM_W-1:0]   id_imm;
  logic               id_writes;
  logic               id_illegal;

  logic               ex_we;
  logic               ex_illegal;
  logic               ex_carry;
  logic [DATA_W-1:0]  ex_res;
  logic [REG_AW-1:0]  ex_rd;

  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_c;
  logic               global_stall;
  logic               hazard_stall;
  logic               accept;

  assign id_op      = id_instr[INSTR_W-1 -: 4];
  assign id_rd      = id_instr[IMM_W+REG_AW +: REG_AW];
  assign id_rs      = id_instr[IMM_W +: REG_AW];
  assign id_imm     = id_instr[IMM_W-1:0];
  assign id_writes  = (id_op >= 4'd1) && (id_op <= 4'd10);
  assign id_illegal = (id_op >= 4'd11);

`ifdef PIPE_FWD_EN
  assign rs_val       = (ex_we && (ex_rd == id_rs)) ? ex_res : rf[id_rs];
  assign rd_val       = (ex_we && (ex_rd == id_rd)) ? ex_res : rf[id_rd];
  assign hazard_stall = 1'b0;
`else
  logic uses_rs;
  logic uses_rd;

  assign uses_rs      = id_writes && (id_op != 4'd5);
  assign uses_rd      = (id_op >= 4'd6) && (id_op <= 4'd10);
  assign rs_val       = rf[id_rs];
  assign rd_val       = rf[id_rd];
  // Only the EX stage can hold a pending write; WB commits on the edge it loads.
  assign hazard_stall = id_valid && ex_we &&
                        ((uses_rs && (ex_rd == id_rs)) || (uses_rd && (ex_rd == id_rd)));
`endif

  assign global_stall = result_valid && !result_ready;
  assign instr_ready  = !global_stall && !hazard_stall && rst_n;
  assign accept       = instr_valid && instr_ready;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (id_op)
      4'd1:  {alu_c, alu_res} = {1'b0, rs_val} + {{DATA_W{1'b0}}, 1'b1};
      4'd2:  {alu_c, alu_res} = {1'b0, rs_val} - {{DATA_W{1'b0}}, 1'b1};
      4'd3:  begin alu_res = rs_val << 1; alu_c = rs_val[DATA_W-1]; end
      4'd4:  begin alu_res = rs_val >> 1; alu_c = rs_val[0]; end
      4'd5:  alu_res = DATA_W'(id_imm);
      4'd6:  {alu_c, alu_res} = {1'b0, rd_val} + {1'b0, rs_val};
      4'd7:  {alu_c, alu_res} = {1'b0, rd_val} - {1'b0, rs_val};
      4'd8:  alu_res = rd_val & rs_val;
      4'd9:  alu_res = rd_val | rs_val;
      4'd10: alu_res = rd_val ^ rs_val;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_instr <= '0;
    end else if (!global_stall) begin
      if (accept) begin
        id_valid <= 1'b1;
        id_instr <= instr_in;
      end else if (!hazard_stall) begin
        id_valid <= 1'b0;
      end
    end
  end

  // A hazard turns the EX slot into a bubble while ID holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_we      <= 1'b0;
      ex_illegal <= 1'b0;
      ex_carry   <= 1'b0;
      ex_res     <= '0;
      ex_rd      <= '0;
    end else if (!global_stall) begin
      ex_we      <= id_valid && !hazard_stall && id_writes;
      ex_illegal <= id_valid && !hazard_stall && id_illegal;
      ex_carry   <= alu_c;
      ex_res     <= alu_res;
      ex_rd      <= id_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      result_out   <= '0;
      result_rd    <= '0;
      result_carry <= 1'b0;
      illegal_op   <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (!global_stall) begin
      result_valid <= ex_we;
      result_out   <= ex_res;
      result_rd    <= ex_rd;
      result_carry <= ex_carry;
      if (ex_illegal) illegal_op <= 1'b1;
      if (ex_we) rf[ex_rd] <= ex_res;
    end
  end

endmodule

// File: tb/tb_pipelined_alu_core.sv
// Directed self-checking bench for pipelined_alu_core (default 8-bit data, 4 registers).
// Works with and without PIPE_FWD_EN; only the expected timing differs.
module tb_pipelined_alu_core;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_in;
  logic        result_valid;
  logic        result_ready;
  logic [7:0]  result_out;
  logic [1:0]  result_rd;
  logic        result_carry;
  logic        illegal_op;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] q_out [$];
  logic [1:0] q_rd [$];
  logic       q_c [$];
  int         q_cyc [$];

  pipelined_alu_core dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_in(instr_in),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_out(result_out), .result_rd(result_rd), .result_carry(result_carry),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      q_out.push_back(result_out);
      q_rd.push_back(result_rd);
      q_c.push_back(result_carry);
      q_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_out.delete(); q_rd.delete(); q_c.delete(); q_cyc.delete();
  endtask

  task automatic send(input logic [15:0] ins);
    int n = 0;
    instr_valid = 1'b1;
    instr_in = ins;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!instr_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout instr=%h instr_ready=%b required=1", ins, instr_ready);
    end
    tick();
  endtask

  task automatic drain(input int n);
    instr_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    n_vec++;
    if ({result_valid, result_out, result_rd, result_carry, illegal_op, instr_ready} !== 14'b0) begin
      n_err++;
      $display("FAIL reset_outputs got v=%b out=%h rd=%0d c=%b ill=%b rdy=%b required all 0",
               result_valid, result_out, result_rd, result_carry, illegal_op, instr_ready);
    end
  endtask

  task automatic test_latency();
    clear_q();
    instr_valid = 1'b1;
    instr_in = 16'h1400;            // INC r1,r0
    n_vec++;
    if (instr_ready !== 1'b1) begin
      n_err++; $display("FAIL lat_ready got %b required 1", instr_ready);
    end
    tick();
    instr_valid = 1'b0;
    n_vec++;
    if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_early1 result_valid got %b required 0", result_valid);
    end
    tick();
    n_vec++;
    if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_early2 result_valid got %b required 0", result_valid);
    end
    tick();
    n_vec++;
    if ({result_valid, result_out, result_rd, result_carry} !== {1'b1, 8'h01, 2'd1, 1'b0}) begin
      n_err++;
      $display("FAIL lat_result got v=%b out=%h rd=%0d c=%b required v=1 out=01 rd=1 c=0",
               result_valid, result_out, result_rd, result_carry);
    end
    tick();
    n_vec++;
    if (result_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_single result_valid got %b required 0", result_valid);
    end
    drain(3);
  endtask

  task automatic test_legacy();
    logic [15:0] prog [7] = '{16'h5002, 16'h1000, 16'h5004, 16'h2000, 16'h3000, 16'h5008, 16'h4000};
    logic [7:0]  exp [7]  = '{8'h02, 8'h03, 8'h04, 8'h03, 8'h06, 8'h08, 8'h04};
    clear_q();
    foreach (prog[i]) send(prog[i]);
    drain(8);
    n_vec++;
    if (q_out.size() != 7) begin
      n_err++; $display("FAIL legacy_count got %0d required 7", q_out.size());
    end
    for (int i = 0; i < 7; i++) begin
      n_vec++;
      if (i >= q_out.size()) begin
        n_err++; $display("FAIL legacy_%0d got missing required %h", i, exp[i]);
      end else if ({q_out[i], q_rd[i], q_c[i]} !== {exp[i], 2'd0, 1'b0}) begin
        n_err++;
        $display("FAIL legacy_%0d got out=%h rd=%0d c=%b required out=%h rd=0 c=0",
                 i, q_out[i], q_rd[i], q_c[i], exp[i]);
      end
    end
  endtask

  task automatic test_carry_back_to_back();
    clear_q();
    send(16'h50FF);                 // LDI r0,0xFF
    send(16'h1400);                 // INC r1,r0
    instr_valid = 1'b0;
    n_vec++;
    if (instr_ready !== FWD) begin
      n_err++; $display("FAIL b2b_ready_hazard got %b required %b", instr_ready, FWD);
    end
    tick();
    n_vec++;
    if (instr_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready_after got %b required 1", instr_ready);
    end
    drain(6);
    n_vec++;
    if (q_out.size() != 2) begin
      n_err++; $display("FAIL b2b_count got %0d required 2", q_out.size());
    end else begin
      n_vec++;
      if ({q_out[0], q_rd[0], q_c[0]} !== {8'hFF, 2'd0, 1'b0}) begin
        n_err++; $display("FAIL b2b_ldi got out=%h rd=%0d c=%b required FF/0/0", q_out[0], q_rd[0], q_c[0]);
      end
      n_vec++;
      if ({q_out[1], q_rd[1], q_c[1]} !== {8'h00, 2'd1, 1'b1}) begin
        n_err++; $display("FAIL b2b_inc got out=%h rd=%0d c=%b required 00/1/1", q_out[1], q_rd[1], q_c[1]);
      end
      n_vec++;
      if (q_cyc[1] - q_cyc[0] != (FWD ? 1 : 2)) begin
        n_err++; $display("FAIL b2b_gap got %0d required %0d", q_cyc[1] - q_cyc[0], FWD ? 1 : 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_out [3] = '{8'h11, 8'h22, 8'h33};
    logic [1:0] exp_rd [3]  = '{2'd2, 2'd3, 2'd1};
    clear_q();
    result_ready = 1'b0;
    send(16'h5811);                 // LDI r2,0x11
    send(16'h5C22);                 // LDI r3,0x22
    send(16'h5433);                 // LDI r1,0x33
    instr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({result_valid, result_out, instr_ready} !== {1'b1, 8'h11, 1'b0}) begin
        n_err++;
        $display("FAIL stall_hold_%0d got v=%b out=%h rdy=%b required v=1 out=11 rdy=0",
                 k, result_valid, result_out, instr_ready);
      end
      tick();
    end
    result_ready = 1'b1;
    drain(6);
    n_vec++;
    if (q_out.size() != 3) begin
      n_err++; $display("FAIL stall_count got %0d required 3", q_out.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (i >= q_out.size()) begin
        n_err++; $display("FAIL stall_order_%0d got missing required %h", i, exp_out[i]);
      end else if ({q_out[i], q_rd[i]} !== {exp_out[i], exp_rd[i]}) begin
        n_err++;
        $display("FAIL stall_order_%0d got out=%h rd=%0d required out=%h rd=%0d",
                 i, q_out[i], q_rd[i], exp_out[i], exp_rd[i]);
      end
    end
  endtask

  // Registers on entry: r1=0x33, r2=0x11, r3=0x22.
  task automatic test_two_operand_ops();
    logic [15:0] prog [5] = '{16'h6B00, 16'h7E00, 16'h8B00, 16'h9700, 16'hAF00};
    logic [7:0]  exp_out [5] = '{8'h33, 8'hEF, 8'h23, 8'hFF, 8'h00};
    logic [1:0]  exp_rd [5]  = '{2'd2, 2'd3, 2'd2, 2'd1, 2'd3};
    logic        exp_c [5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    clear_q();
    foreach (prog[i]) send(prog[i]);
    drain(8);
    n_vec++;
    if (q_out.size() != 5) begin
      n_err++; $display("FAIL ops_count got %0d required 5", q_out.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (i >= q_out.size()) begin
        n_err++; $display("FAIL ops_%0d got missing required %h", i, exp_out[i]);
      end else if ({q_out[i], q_rd[i], q_c[i]} !== {exp_out[i], exp_rd[i], exp_c[i]}) begin
        n_err++;
        $display("FAIL ops_%0d got out=%h rd=%0d c=%b required out=%h rd=%0d c=%b",
                 i, q_out[i], q_rd[i], q_c[i], exp_out[i], exp_rd[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_illegal();
    clear_q();
    n_vec++;
    if (illegal_op !== 1'b0) begin
      n_err++; $display("FAIL illegal_before got %b required 0", illegal_op);
    end
    send(16'hF000);
    drain(5);
    n_vec++;
    if (q_out.size() != 0 || illegal_op !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_flag got results=%0d illegal_op=%b required results=0 illegal_op=1",
               q_out.size(), illegal_op);
    end
    send(16'h5005);                 // LDI r0,5
    send(16'h1400);                 // INC r1,r0
    drain(6);
    n_vec++;
    if (q_out.size() != 2) begin
      n_err++; $display("FAIL illegal_after_count got %0d required 2", q_out.size());
    end else if ({q_out[1], q_rd[1], q_c[1]} !== {8'h06, 2'd1, 1'b0}) begin
      n_err++; $display("FAIL illegal_after_inc got out=%h rd=%0d c=%b required 06/1/0", q_out[1], q_rd[1], q_c[1]);
    end
    n_vec++;
    if (illegal_op !== 1'b1) begin
      n_err++; $display("FAIL illegal_sticky got %b required 1", illegal_op);
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] k;
    clear_q();
    send(16'h5077);                 // LDI r0,0x77
    send(16'h5466);                 // LDI r1,0x66
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    rst_n = 1'b1;
    drain(4);
    n_vec++;
    if (q_out.size() != 0) begin
      n_err++; $display("FAIL rst_flight_results got %0d required 0", q_out.size());
    end
    clear_q();
    for (int i = 0; i < 4; i++) begin
      k = 2'(i);
      send({4'h9, k, k, 8'h00});    // OR rk,rk reads back rk
    end
    drain(8);
    n_vec++;
    if (q_out.size() != 4) begin
      n_err++; $display("FAIL rst_readback_count got %0d required 4", q_out.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= q_out.size()) begin
        n_err++; $display("FAIL rst_reg_%0d got missing required 00", i);
      end else if ({q_out[i], q_rd[i]} !== {8'h00, 2'(i)}) begin
        n_err++; $display("FAIL rst_reg_%0d got out=%h rd=%0d required out=00 rd=%0d", i, q_out[i], q_rd[i], i);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr_in = 16'h0000;
    result_ready = 1'b1;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_latency();
    test_legacy();
    test_carry_back_to_back();
    test_backpressure();
    test_two_operand_ops();
    test_illegal();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_alu_core.md
# pipelined_alu_core

Parametrised successor to the 8-bit pipelined processor: a 3-stage (ID, EX, WB) accumulator-style execution core with a small register file. Extensions over the previous core:
- configurable data and immediate widths;
- more opcodes;
- valid/ready handshakes on instruction input and result output;
- RAW hazard handling, by forwarding or by interlock.

It sits between the instruction source and any result consumer.

## Interface
- DATA_W, 8: datapath and register width (≥ 4).
- IMM_W, 8: immediate field width (≤ DATA_W).
- REG_AW, 2: register address width; register count NREGS = 2**REG_AW.
- INSTR_W (localparam) = 4 + 2*REG_AW + IMM_W. Default 16.
- Instruction field layout: {op[3:0], rd, rs, imm}.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instr_in is valid.
- instr_ready  out  1  core accepts instr_in this cycle.
- instr_in  in  INSTR_W  instruction.
- result_valid  out  1  result_out/result_rd/result_carry valid.
- result_ready  in  1  consumer accepts the result.
- result_out  out  DATA_W  written value.
- result_rd  out  REG_AW  destination register.
- result_carry  out  1  carry/borrow/shift-out bit.
- illegal_op  out  1  sticky flag: an illegal opcode was retired.

## Operation
- Opcodes (all arithmetic is modulo 2**DATA_W):
  - 0 NOP.
  - 1 INC: rd=rs+1. Carry = carry-out.
  - 2 DEC: rd=rs-1. Carry = borrow.
  - 3 SHL: rd=rs<<1. Carry = old MSB.
  - 4 SHR: rd=rs>>1, logical. Carry = old LSB.
  - 5 LDI: rd=zero-extended imm. Carry = 0.
  - 6 ADD: rd=rd+rs. Carry = carry-out.
  - 7 SUB: rd=rd-rs. Carry = borrow.
  - 8 AND, 9 OR, 10 XOR: rd=rd op rs. Carry = 0.
  - 11-15 are illegal.
- A transfer occurs on a rising edge with instr_valid & instr_ready.
- ID stage: holds the accepted instruction. Operands rd and rs are read from the register file, with bypass (see Configuration). The ALU evaluates combinationally.
- EX register: captures the ALU result, rd, carry, and a write-enable bit.
- WB/output register: loads from the EX register. The register file is written on the same edge. A write occurs only for opcodes 1-10.
- result_valid is asserted only for opcodes 1-10.
- NOP and illegal opcodes travel as bubbles: no register write, no result_valid.
- Each retired illegal opcode sets illegal_op to 1. It stays 1 until reset.
- Backpressure uses a global stall. When result_valid & !result_ready:
  - all stage registers hold;
  - the register file is not written again;
  - instr_ready = 0.
- instr_ready = !global_stall & !hazard_stall & rst_n.
- Results retire strictly in program order, never dropped or duplicated.

## Timing
- Reset (asynchronous, while rst_n=0):
  - all registers and stage valids cleared;
  - result_out=0, result_rd=0, result_carry=0, result_valid=0, illegal_op=0, instr_ready=0.
- Reset mid-operation discards in-flight instructions; no write-back occurs.
- Latency, for an instruction accepted at edge N with no stalls:
  - ID during cycle N→N+1;
  - EX register loaded at edge N+1;
  - result_valid and register write at edge N+2.
- Throughput: 1 instruction/cycle.
- Hazard: the ID instruction reads a register (rs, or rd for ADD/SUB/logic ops) equal to the EX-stage rd with write enabled.
  - WB writes commit at the edge the WB register loads. No WB-stage hazard therefore exists.
- Simultaneous result_ready=0 and a hazard: the global stall takes priority; the bubble is not inserted twice.

## Configuration
- PIPE_FWD_EN defined:
  - the EX-stage result bypasses to the ID operand mux;
  - dependent back-to-back instructions issue every cycle;
  - hazard_stall is constant 0.
- PIPE_FWD_EN undefined:
  - on a hazard, instr_ready=0 and ID holds for one cycle;
  - a bubble is inserted into EX;
  - dependent back-to-back instructions retire with a one-cycle gap.
- Architectural results are identical in both builds.

## Test plan
- Reset, then INC r1,r0 -> result_out=0x01, result_rd=1, result_carry=0, result_valid 2 cycles after acceptance.
- Legacy sequence, each on r0:
  - LDI 2, INC -> 3;
  - LDI 4, DEC -> 3;
  - SHL -> 6;
  - LDI 8, SHR -> 4.
- LDI r0,0xFF then INC r1,r0 back-to-back -> result 0x00, carry=1.
  - With PIPE_FWD_EN: results on consecutive cycles.
  - Without PIPE_FWD_EN: one idle cycle and instr_ready low for one cycle.
- Three instructions in flight, result_ready low for 3 cycles:
  - result_out holds the first value and instr_ready=0;
  - all three retire in order after release, each exactly once.
- Opcode 0xF -> no result_valid, illegal_op=1, stays 1. A following INC behaves normally.
- rst_n pulsed low with 2 instructions in flight -> no result_valid, all registers read 0 afterwards.
